// File: rtl/joy_pkg.sv
// Shared definitions for the DB15 joystick adapter emulator: button bit
// positions, transmitter state encoding and frame-length helper.
package joy_pkg;

  localparam int unsigned JOY_BIT_R     = 0;
  localparam int unsigned JOY_BIT_LEFT  = 1;
  localparam int unsigned JOY_BIT_DOWN  = 2;
  localparam int unsigned JOY_BIT_UP    = 3;
  localparam int unsigned JOY_BIT_A     = 4;
  localparam int unsigned JOY_BIT_B     = 5;
  localparam int unsigned JOY_BIT_C     = 6;
  localparam int unsigned JOY_BIT_D     = 7;
  localparam int unsigned JOY_BIT_E     = 8;
  localparam int unsigned JOY_BIT_F     = 9;
  localparam int unsigned JOY_BIT_START = 10;
  localparam int unsigned JOY_BIT_L     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } joy_tx_state_t;

  function automatic int unsigned frame_len(input int unsigned bits_per_player);
    return 2 * bits_per_player;
  endfunction

endpackage

// File: rtl/joy_sync_filter.sv
// Synchronizer (reset to idle-high), optional stability filter and rising-edge
// detect for one asynchronous reader line. Filter enabled by JOY_TX_GLITCH_FILTER_EN.
module joy_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '1;
    else          sync <= {sync[SYNC_STAGES-2:0], line};
  end

`ifdef JOY_TX_GLITCH_FILTER_EN
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] cnt;
  logic          filt;

  // Level changes only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (sync[SYNC_STAGES-1] == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      filt <= sync[SYNC_STAGES-1];
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level = filt;
`else
  assign level = sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b1;
    else          prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick adapter emulator: answers the reader's load/clock
// handshake and shifts {~joystick1, ~joystick2} out MSB first on joy_data.
module joy_db15_tx
  import joy_pkg::*;
#(
  parameter int unsigned BITS_PER_PLAYER = 12,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned FILTER_LEN      = 4
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     joy_clk,
  input  logic                                     joy_load,
  input  logic [BITS_PER_PLAYER-1:0]               joystick1,
  input  logic [BITS_PER_PLAYER-1:0]               joystick2,
  output logic                                     joy_data,
  output logic                                     frame_done,
  output logic [$clog2(2*BITS_PER_PLAYER+1)-1:0]   bit_index
);

  localparam int unsigned F  = frame_len(BITS_PER_PLAYER);
  localparam int unsigned IW = $clog2(2*BITS_PER_PLAYER+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(F - 1);

  joy_tx_state_t state, state_next;
  logic [F-1:0]  sr;
  logic          clk_level, clk_rise;
  logic          load_level, load_rise;
  logic          do_load, do_shift, finish;

  joy_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line    (joy_clk),
    .level   (clk_level),
    .rise    (clk_rise)
  );

  joy_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_load_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line    (joy_load),
    .level   (load_level),
    .rise    (load_rise)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Load low overrides everything; in LOAD the load release equals a load rise,
  // and a clock edge coincident with it is ignored so bit 0 is not skipped.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    finish     = 1'b0;
    if (!load_level) begin
      do_load    = 1'b1;
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:  ;
        LOAD:  if (load_rise) state_next = SHIFT;
        SHIFT: if (clk_rise) begin
                 do_shift = 1'b1;
                 if (bit_index == LAST_IDX) begin
                   finish     = 1'b1;
                   state_next = DONE;
                 end
               end
        DONE:  if (clk_rise) do_shift = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr         <= '1;
      bit_index  <= '0;
      frame_done <= 1'b0;
      joy_data   <= 1'b1;
    end else begin
      frame_done <= finish;
      joy_data   <= (state == IDLE) ? 1'b1 : sr[F-1];
      if (do_load) begin
        sr        <= {~joystick1, ~joystick2};
        bit_index <= '0;
      end else if (do_shift) begin
        sr <= {sr[F-2:0], 1'b1};
        if (state == SHIFT) bit_index <= bit_index + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: drives the reader-side load/clock handshake
// and checks the serial stream, bit_index and frame_done against expected values.
module tb_joy_db15_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_clk = 1'b0;
  logic        joy_load = 1'b1;
  logic [11:0] joystick1 = '0;
  logic [11:0] joystick2 = '0;
  logic        joy_data;
  logic        frame_done;
  logic [4:0]  bit_index;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned done_cnt = 0;
  int unsigned base;
  logic [11:0] a_j1, a_j2;

  localparam int unsigned HALF = 8;

  joy_db15_tx #(.BITS_PER_PLAYER(12), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .bit_index  (bit_index)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (frame_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_edge();
    joy_clk = 1'b1;
    wait_clk(HALF);
    joy_clk = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic load_pulse();
    joy_load = 1'b0;
    wait_clk(HALF);
    joy_load = 1'b1;
    wait_clk(HALF);
  endtask

  // Expected line level for stream position i (0 = first bit after load).
  function automatic logic exp_bit(input logic [11:0] j1, input logic [11:0] j2, input int i);
    logic [23:0] w;
    w = {~j1, ~j2};
    if (i > 23) return 1'b1;
    return w[23-i];
  endfunction

  initial begin
    wait_clk(3);
    check("reset_data", joy_data, 1);
    check("reset_done", frame_done, 0);
    check("reset_idx", bit_index, 0);
    reset_n = 1'b1;
    wait_clk(3);

    for (int i = 0; i < 5; i++) begin
      clk_edge();
      check("idle_data", joy_data, 1);
      check("idle_idx", bit_index, 0);
    end
    check("idle_done", done_cnt, 0);

    // Full frame plus six overrun clocks; inputs change mid-frame.
    joystick1 = 12'h001;
    joystick2 = 12'h800;
    a_j1 = joystick1;
    a_j2 = joystick2;
    base = done_cnt;
    load_pulse();
    check("frame_idx0", bit_index, 0);
    check("frame_bit0", joy_data, exp_bit(a_j1, a_j2, 0));
    for (int e = 1; e <= 30; e++) begin
      clk_edge();
      if (e == 5) joystick1 = 12'hFFF;
      check($sformatf("frame_bit%0d", e), joy_data, exp_bit(a_j1, a_j2, e));
      if (e == 11 || e == 12) check($sformatf("frame_zero%0d", e), joy_data, 0);
      if (e == 23) check("frame_done_early", done_cnt - base, 0);
      if (e == 24) begin
        check("frame_done24", done_cnt - base, 1);
        check("frame_idx24", bit_index, 24);
      end
      if (e < 24) check($sformatf("frame_idx%0d", e), bit_index, e);
    end
    check("frame_idx_sat", bit_index, 24);
    check("frame_done_once", done_cnt - base, 1);

    // Abort after 10 edges and restart with A pressed.
    joystick1 = 12'h001;
    joystick2 = 12'h800;
    base = done_cnt;
    load_pulse();
    for (int e = 1; e <= 10; e++) clk_edge();
    check("abort_idx10", bit_index, 10);
    joystick1 = 12'h010;
    joystick2 = 12'h000;
    load_pulse();
    check("abort_idx0", bit_index, 0);
    check("abort_no_done", done_cnt - base, 0);
    check("abort_bit0", joy_data, 1);
    for (int e = 1; e <= 24; e++) begin
      clk_edge();
      check($sformatf("abort_bit%0d", e), joy_data, (e == 7) ? 0 : 1);
    end
    check("abort_done", done_cnt - base, 1);

    // Load release coincident with a clock rise: that rise must not shift.
    joystick1 = 12'h800;
    joystick2 = 12'h000;
    joy_load = 1'b0;
    wait_clk(HALF);
    joy_load = 1'b1;
    joy_clk = 1'b1;
    wait_clk(HALF);
    check("coinc_bit0", joy_data, 0);
    check("coinc_idx0", bit_index, 0);
    joy_clk = 1'b0;
    wait_clk(HALF);
    clk_edge();
    check("coinc_bit1", joy_data, 1);
    check("coinc_idx1", bit_index, 1);

    // Asynchronous reset mid-frame.
    joystick1 = 12'h001;
    joystick2 = 12'h800;
    load_pulse();
    for (int e = 1; e <= 7; e++) clk_edge();
    check("pre_rst_idx", bit_index, 7);
    base = done_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_data", joy_data, 1);
    check("rst_idx", bit_index, 0);
    check("rst_done", frame_done, 0);
    wait_clk(1);
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      clk_edge();
      check("post_rst_data", joy_data, 1);
      check("post_rst_idx", bit_index, 0);
    end
    check("post_rst_no_done", done_cnt - base, 0);
    load_pulse();
    check("reload_bit0", joy_data, 1);
    for (int e = 1; e <= 11; e++) clk_edge();
    check("reload_bit11", joy_data, 0);
    check("reload_idx11", bit_index, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
